// File: rtl/hazard_ctrl_if.sv
// Pipeline-side handshake bundle for the EX-stage hazard/sequencing controller.
// master = pipeline datapath (drives stage info, consumes controls)
// slave  = hazard_ctrl
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    // EX / ID stage information
    logic             MemRead_ex;
    logic [4:0]       rdAddr_ex;
    logic [4:0]       rs1Addr_id;
    logic [4:0]       rs2Addr_id;
    logic             rs1Used_id;
    logic             rs2Used_id;
    logic             JumpFlag_ex;
    logic             MDOp_ex;
    logic             md_done;

    // pipeline register controls
    logic             PC_IFWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;

    // mul/div handshake and status
    logic             md_start;
    logic             md_sel;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id,
               rs1Used_id, rs2Used_id, JumpFlag_ex, MDOp_ex, md_done,
        input  PC_IFWrite, IF_ID_Write, ID_EX_Write,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               md_start, md_sel, md_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id,
               rs1Used_id, rs2Used_id, JumpFlag_ex, MDOp_ex, md_done,
        output PC_IFWrite, IF_ID_Write, ID_EX_Write,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               md_start, md_sel, md_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// EX-stage pipeline sequencing controller: load-use stalls, jump flushes,
// multi-cycle mul/div hold with timeout, and saturating stall/flush counters.
// Pipeline controls are combinational so they gate the same-cycle register loads.
module hazard_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    localparam int unsigned        WAIT_W     = $clog2(MD_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MD_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              md_err_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    logic              rs1_hit;
    logic              rs2_hit;
    logic              load_use;

    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic              start;
    logic              sel;
    logic              err_set;

    // Load in EX writes a register that the ID instruction actually reads.
    always_comb begin
        rs1_hit  = bus.rs1Used_id && (bus.rs1Addr_id == bus.rdAddr_ex);
        rs2_hit  = bus.rs2Used_id && (bus.rs2Addr_id == bus.rdAddr_ex);
        load_use = bus.MemRead_ex && (bus.rdAddr_ex != 5'd0) && (rs1_hit || rs2_hit);
    end

    // Next state, wait counter and same-cycle pipeline controls.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        start        = 1'b0;
        sel          = 1'b0;
        err_set      = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.JumpFlag_ex) begin
                        // ID instruction is discarded, so any hazard against it is moot
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (bus.MDOp_ex) begin
                        start        = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_nxt    = MD_WAIT;
                        wait_cnt_nxt = WAIT_W'(1);
                    end else if (load_use) begin
                        // single bubble: the load leaves EX next cycle
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end

                MD_WAIT: begin
                    if (bus.md_done) begin
                        sel          = 1'b1;
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        // abort: release the pipeline with the ALU result
                        err_set      = 1'b1;
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            endcase
        end
    end

    // FSM state and mul/div wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Sticky mul/div timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_err_q <= 1'b0;
        end else if (err_set) begin
            md_err_q <= 1'b1;
        end
    end

    // Saturating stall counter: every cycle the PC is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!pc_write && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Saturating flush counter: jump events only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q <= '0;
        end else if (if_id_flush && (flush_q != CNT_MAX)) begin
            flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.PC_IFWrite   = pc_write;
    assign bus.IF_ID_Write  = if_id_write;
    assign bus.ID_EX_Write  = id_ex_write;
    assign bus.IF_ID_Flush  = if_id_flush;
    assign bus.ID_EX_Flush  = id_ex_flush;
    assign bus.EX_MEM_Flush = ex_mem_flush;
    assign bus.md_start     = start;
    assign bus.md_sel       = sel;
    assign bus.md_err       = md_err_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_hazard_ctrl;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MD_TIMEOUT = 8;
    localparam int          CNT_SAT    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .CNT_W      (CNT_W),
        .MD_TIMEOUT (MD_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_busy: a mul/div op has been launched and not yet finished
    // m_age : cycles the pipeline has been held for the current op
    bit m_busy;
    int m_age;
    bit m_err;
    int m_stall;
    int m_flush;

    bit e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf, e_start, e_sel;
    bit hazard;
    int e_ctrl, d_ctrl;

    always @(negedge clk) begin
        if (check_en) begin
            e_pc = 1; e_ifw = 1; e_idw = 1;
            e_iff = 0; e_idf = 0; e_exf = 0; e_start = 0; e_sel = 0;
            hazard = bus.MemRead_ex && (bus.rdAddr_ex != 0) &&
                     ((bus.rs1Used_id && bus.rs1Addr_id == bus.rdAddr_ex) ||
                      (bus.rs2Used_id && bus.rs2Addr_id == bus.rdAddr_ex));

            if (reset) begin
                m_busy = 0; m_age = 0; m_err = 0; m_stall = 0; m_flush = 0;
                e_pc = 0; e_ifw = 0; e_idw = 0;
            end else if (!m_busy) begin
                if (bus.JumpFlag_ex) begin
                    e_iff = 1; e_idf = 1;
                end else if (bus.MDOp_ex) begin
                    e_start = 1; e_pc = 0; e_ifw = 0; e_idw = 0; e_exf = 1;
                end else if (hazard) begin
                    e_pc = 0; e_ifw = 0; e_idf = 1;
                end
            end else begin
                if (bus.md_done) begin
                    e_sel = 1;
                end else if (m_age < MD_TIMEOUT) begin
                    e_pc = 0; e_ifw = 0; e_idw = 0; e_exf = 1;
                end
            end

            e_ctrl = {24'd0, e_pc, e_ifw, e_idw, e_iff, e_idf, e_exf, e_start, e_sel};
            d_ctrl = {24'd0, bus.PC_IFWrite, bus.IF_ID_Write, bus.ID_EX_Write,
                      bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush,
                      bus.md_start, bus.md_sel};
            check("ctrl", d_ctrl, e_ctrl);
            check("md_err", int'(bus.md_err), int'(m_err));
            check("stall_cnt", int'(bus.stall_cnt), m_stall);
            check("flush_cnt", int'(bus.flush_cnt), m_flush);

            // advance to the state after the coming rising edge
            if (!reset) begin
                if (!e_pc && m_stall < CNT_SAT) m_stall++;
                if (e_iff && m_flush < CNT_SAT) m_flush++;
                if (!m_busy) begin
                    if (e_start) begin m_busy = 1; m_age = 1; end
                end else if (bus.md_done) begin
                    m_busy = 0; m_age = 0;
                end else if (m_age >= MD_TIMEOUT) begin
                    m_busy = 0; m_age = 0; m_err = 1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit mr, input int rd, input int r1, input int r2,
                         input bit u1, input bit u2, input bit j, input bit md,
                         input bit done);
        bus.MemRead_ex  = mr;
        bus.rdAddr_ex   = 5'(rd);
        bus.rs1Addr_id  = 5'(r1);
        bus.rs2Addr_id  = 5'(r2);
        bus.rs1Used_id  = u1;
        bus.rs2Used_id  = u2;
        bus.JumpFlag_ex = j;
        bus.MDOp_ex     = md;
        bus.md_done     = done;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        check_en = 1'b1;

        // reset values
        tick(); #2;
        check("rst_pc", int'(bus.PC_IFWrite), 0);
        check("rst_ifw", int'(bus.IF_ID_Write), 0);
        check("rst_stall", int'(bus.stall_cnt), 0);
        check("rst_err", int'(bus.md_err), 0);
        tick();
        reset = 1'b0;

        // load x5, ID reads rs2 = x5
        drive(1, 5, 3, 5, 1, 1, 0, 0, 0); #2;
        check("lu_pc", int'(bus.PC_IFWrite), 0);
        check("lu_ifw", int'(bus.IF_ID_Write), 0);
        check("lu_idf", int'(bus.ID_EX_Flush), 1);
        check("lu_idw", int'(bus.ID_EX_Write), 1);
        tick(); idle(); #2;
        check("lu_stall", int'(bus.stall_cnt), 1);
        check("lu_release", int'(bus.PC_IFWrite), 1);

        // load to x0 never stalls
        tick(); drive(1, 0, 0, 0, 1, 1, 0, 0, 0); #2;
        check("lu_x0_pc", int'(bus.PC_IFWrite), 1);
        check("lu_x0_idf", int'(bus.ID_EX_Flush), 0);
        tick(); idle(); #2;
        check("lu_x0_stall", int'(bus.stall_cnt), 1);

        // jump together with a load-use hazard
        tick(); drive(1, 7, 7, 0, 1, 0, 1, 0, 0); #2;
        check("jmp_iff", int'(bus.IF_ID_Flush), 1);
        check("jmp_idf", int'(bus.ID_EX_Flush), 1);
        check("jmp_pc", int'(bus.PC_IFWrite), 1);
        tick(); idle(); #2;
        check("jmp_flush", int'(bus.flush_cnt), 1);
        check("jmp_stall", int'(bus.stall_cnt), 1);

        // mul/div with md_done four cycles after md_start
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #2;
        check("md_start", int'(bus.md_start), 1);
        check("md_start_pc", int'(bus.PC_IFWrite), 0);
        check("md_start_exf", int'(bus.EX_MEM_Flush), 1);
        for (int i = 1; i < 4; i++) begin
            tick(); #2;
            check("md_hold_start", int'(bus.md_start), 0);
            check("md_hold_pc", int'(bus.PC_IFWrite), 0);
        end
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #2;
        check("md_sel", int'(bus.md_sel), 1);
        check("md_done_pc", int'(bus.PC_IFWrite), 1);
        check("md_done_exf", int'(bus.EX_MEM_Flush), 0);
        tick(); idle(); #2;
        check("md_stall", int'(bus.stall_cnt), 5);

        // timeout: md_done never arrives
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) begin
            tick(); #2;
            check("to_hold_pc", int'(bus.PC_IFWrite), 0);
        end
        tick(); #2;
        check("to_release_pc", int'(bus.PC_IFWrite), 1);
        check("to_release_sel", int'(bus.md_sel), 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
        check("to_err", int'(bus.md_err), 1);
        check("to_late_done_sel", int'(bus.md_sel), 0);
        check("to_stall", int'(bus.stall_cnt), 13);
        tick(); idle(); #2;
        check("to_err_sticky", int'(bus.md_err), 1);

        // reset two cycles into MD_WAIT
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(); tick();
        reset = 1'b1; #1;
        check("rmd_pc", int'(bus.PC_IFWrite), 0);
        check("rmd_exf", int'(bus.EX_MEM_Flush), 0);
        check("rmd_stall", int'(bus.stall_cnt), 0);
        check("rmd_err", int'(bus.md_err), 0);
        tick(); tick();
        reset = 1'b0; idle(); #2;
        check("rmd_run_pc", int'(bus.PC_IFWrite), 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #2;
        check("rmd_restart", int'(bus.md_start), 1);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #2;
        check("rmd_sel", int'(bus.md_sel), 1);

        // 20 consecutive load-use stalls saturate the counter
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        drive(1, 9, 9, 0, 1, 0, 0, 0, 0);
        repeat (20) tick();
        idle(); #2;
        check("sat_stall", int'(bus.stall_cnt), 15);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            reset = ($urandom_range(0, 99) < 3);
            drive($urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 25);
        end
        tick(); reset = 1'b0; idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
